shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
- REQ-001: Parameter width, default 8; bit width of every request and result operand; legal range 2..64.
- REQ-002: Port clk  input  1; the single clock; all state updates on its rising edge.
- REQ-003: Port rst_n  input  1; reset is asynchronous and active-low.
- REQ-004: Port i_valid  input  4; bit k asserts that requester k presents an operand.
- REQ-005: Port i_ready  output  4; bit k asserts that requester k's operand is accepted this cycle.
- REQ-006: Port i_bits  input  4*width; requester k operand in bits [k*width +: width].
- REQ-007: Port i_shift  input  4*clog2(width); requester k shift amount in bits [k*clog2(width) +: clog2(width)].
- REQ-008: Port o_valid  output  1; the result register holds a valid result.
- REQ-009: Port o_ready  input  1; the consumer takes the result this cycle.
- REQ-010: Port o_bits  output  width; the registered shift result.
- REQ-011: Port o_src  output  2; the index of the requester that produced o_bits.

Function
- REQ-012: The block SHALL share one left-shift datapath among 4 requesters through a one-entry output register.
- REQ-013: can_load SHALL equal (!o_valid || o_ready); no requester is accepted when can_load is 0.
- REQ-014: Grant SHALL be round-robin: search starts at pointer ptr (2 bits) and proceeds ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first k with i_valid[k]=1 wins.
- REQ-015: i_ready SHALL be one-hot or zero, asserted only for the winner and only when can_load=1; it is combinational from i_valid, o_valid and o_ready.
- REQ-016: On acceptance of k, the next cycle SHALL present o_valid=1, o_bits=i_bits[k] << i_shift[k] (logical, zero-fill, truncated to width), o_src=k, and ptr=k+1 mod 4.
- REQ-017: Latency SHALL be exactly 1 cycle from acceptance to o_valid; back-to-back acceptance SHALL sustain 1 result/cycle when o_ready=1.
- REQ-018: When o_valid=1 and o_ready=0, o_bits and o_src SHALL hold stable, and no acceptance occurs.
- REQ-019: When o_ready=1 and no request is accepted, o_valid SHALL drop to 0 next cycle; o_bits/o_src SHALL keep their last values.
- REQ-020: A shift amount >= width (possible for non-power-of-2 width) SHALL yield all-zero o_bits.
- REQ-021: ptr SHALL change only on acceptance; it wraps from 3 to 0.
- REQ-022: A requester holding i_valid while not granted SHALL be served within 4 acceptances (starvation bound).

Reset
- REQ-023: While rst_n=0: o_valid=0, o_bits=0, o_src=0, ptr=0, i_ready=0, regardless of clk.
- REQ-024: Reset asserted mid-transfer SHALL discard the held result; after release, the first acceptance uses ptr=0.

Configuration
- REQ-025: Macro SHIFT_ARBITER_ROTATE_EN, when defined, SHALL replace the shift with a left rotate: o_bits = rotl(i_bits[k], i_shift[k] mod width), bits leaving MSB re-entering at LSB.
- REQ-026: Without SHIFT_ARBITER_ROTATE_EN, the logical shift of REQ-016 and REQ-020 SHALL apply; handshake, arbitration and timing are identical in both builds.

Verification (width=8)
- REQ-027: Reset, then i_valid=0001, i_bits[0]=0x81, i_shift[0]=1, o_ready=1 -> i_ready=0001; next cycle o_valid=1, o_bits=0x02 (0x03 with ROTATE_EN), o_src=0.
- REQ-028: i_valid=1111 held, o_ready=1, from reset -> grants 0,1,2,3,0 on consecutive cycles, o_src following one cycle later.
- REQ-029: o_valid=1, o_ready=0 for 3 cycles with i_valid=0010 -> i_ready=0000 and o_bits stable; on o_ready=1, i_ready=0010 in the same cycle.
- REQ-030: width=6, i_bits=0x3F, i_shift=7 -> o_bits=0x00 (with ROTATE_EN, shift 7 mod 6=1 -> 0x3F).
- REQ-031: rst_n pulsed low asynchronously while o_valid=1 -> o_valid=0 immediately; next grant with i_valid=1010 goes to requester 1.

Source files
------------

// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//
// Four requesters share a single left-shift datapath. A round-robin arbiter
// picks one of them, and the shifted operand is captured in a one-entry
// output register that uses a valid/ready handshake.
//
// Build option:
//   SHIFT_ARBITER_ROTATE_EN - when defined, the datapath rotates left by
//                             (shift mod width) instead of performing a
//                             zero-fill logical shift. The handshake,
//                             arbitration and timing are the same in both
//                             builds.
//
// Parameters:
//   width    - operand/result width (2..64)
//
// Ports:
//   clk      - clock; all state updates on the rising edge
//   rst_n    - asynchronous active-low reset
//   i_valid  - [3:0] requester k presents an operand
//   i_ready  - [3:0] one-hot grant; requester k's operand is accepted this cycle
//   i_bits   - [4*width-1:0] operand for requester k at [k*width +: width]
//   i_shift  - [4*sw-1:0] shift amount for requester k at [k*sw +: sw]
//   o_valid  - the result register holds a valid result
//   o_ready  - the consumer takes the result this cycle
//   o_bits   - [width-1:0] registered shift result
//   o_src    - [1:0] index of the requester that produced o_bits
// -----------------------------------------------------------------------------
module shift_arbiter #(
    parameter int width = 8,
    localparam int sw = (width > 1) ? $clog2(width) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           i_valid,
    output logic [3:0]           i_ready,
    input  logic [4*width-1:0]   i_bits,
    input  logic [4*sw-1:0]      i_shift,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [width-1:0]     o_bits,
    output logic [1:0]           o_src
);

    logic [1:0]        ptr_reg;
    logic              o_valid_reg;
    logic [width-1:0]  o_bits_reg;
    logic [1:0]        o_src_reg;

    logic              can_load;
    logic              found;
    logic              accept;
    logic [1:0]        win;
    logic [1:0]        idx;
    logic [3:0]        grant;
    logic [width-1:0]  res [4];

    // Each requester gets its own shifter. Only the winner's result is
    // loaded, which keeps the mux after the shift and off the grant path.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_req
            logic [width-1:0] op;
            logic [sw-1:0]    amt;
            assign op  = i_bits[gi*width +: width];
            assign amt = i_shift[gi*sw +: sw];
`ifdef SHIFT_ARBITER_ROTATE_EN
            logic [sw-1:0]      rot;
            logic [2*width-1:0] dbl;
            assign rot = sw'(32'(amt) % width);
            // The upper half of {op,op} << rot is op rotated left by rot.
            assign dbl = {op, op} << rot;
            assign res[gi] = dbl[2*width-1:width];
`else
            // Amounts >= width shift every bit out, giving zero.
            assign res[gi] = op << amt;
`endif
        end
    endgenerate

    // The register can take a new result if it is empty or is being drained.
    assign can_load = !o_valid_reg || o_ready;

    // Round-robin search: ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    always_comb begin
        found = 1'b0;
        win   = ptr_reg;
        idx   = ptr_reg;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_reg + 2'(i);
            if (!found && i_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // rst_n is included so the grant is forced low while reset is held.
    assign accept  = found && can_load && rst_n;
    assign grant   = accept ? (4'b0001 << win) : 4'b0000;
    assign i_ready = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg     <= 2'd0;
            o_valid_reg <= 1'b0;
            o_bits_reg  <= '0;
            o_src_reg   <= 2'd0;
        end else begin
            if (accept) begin
                o_valid_reg <= 1'b1;
                o_bits_reg  <= res[win];
                o_src_reg   <= win;
                ptr_reg     <= win + 2'd1;
            end else if (o_ready) begin
                // The result was drained and nothing replaced it. o_bits and
                // o_src keep their last values.
                o_valid_reg <= 1'b0;
            end
        end
    end

    assign o_valid = o_valid_reg;
    assign o_bits  = o_bits_reg;
    assign o_src   = o_src_reg;

endmodule

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter
//
// Directed testbench for shift_arbiter. It instantiates a width=8 DUT for
// handshake and arbitration tests and a width=6 DUT for shift amounts that
// reach or exceed the width. Expected values are computed by hand. When
// SHIFT_ARBITER_ROTATE_EN is defined, the bench uses the rotate results.
// -----------------------------------------------------------------------------
module tb_shift_arbiter;

`ifdef SHIFT_ARBITER_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // width = 8 instance
    logic [3:0]  i_valid8;
    logic [3:0]  i_ready8;
    logic [31:0] i_bits8;
    logic [11:0] i_shift8;
    logic        o_valid8;
    logic        o_ready8;
    logic [7:0]  o_bits8;
    logic [1:0]  o_src8;

    // width = 6 instance
    logic [3:0]  i_valid6;
    logic [3:0]  i_ready6;
    logic [23:0] i_bits6;
    logic [11:0] i_shift6;
    logic        o_valid6;
    logic        o_ready6;
    logic [5:0]  o_bits6;
    logic [1:0]  o_src6;

    int checks = 0;
    int passes = 0;

    logic [7:0] exp8 [4];

    always #5 clk = ~clk;

    shift_arbiter #(.width(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid8),
        .i_ready (i_ready8),
        .i_bits  (i_bits8),
        .i_shift (i_shift8),
        .o_valid (o_valid8),
        .o_ready (o_ready8),
        .o_bits  (o_bits8),
        .o_src   (o_src8)
    );

    shift_arbiter #(.width(6)) dut6 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid6),
        .i_ready (i_ready6),
        .i_bits  (i_bits6),
        .i_shift (i_shift6),
        .o_valid (o_valid6),
        .o_ready (o_ready6),
        .o_bits  (o_bits6),
        .o_src   (o_src6)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
            $display("ok   %s got=%0h", tag, got);
        end else begin
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req8(input int k, input logic [7:0] b, input logic [2:0] s);
        i_bits8[k*8 +: 8]  = b;
        i_shift8[k*3 +: 3] = s;
    endtask

    task automatic set_req6(input int k, input logic [5:0] b, input logic [2:0] s);
        i_bits6[k*6 +: 6]  = b;
        i_shift6[k*3 +: 3] = s;
    endtask

    initial begin
        exp8[0] = ROT ? 8'h03 : 8'h02;   // 0x81 << 1
        exp8[1] = 8'hF0;                 // 0x0F << 4
        exp8[2] = ROT ? 8'h2D : 8'h28;   // 0xA5 << 3
        exp8[3] = 8'h80;                 // 0x01 << 7

        i_valid8 = 4'b1111; i_bits8 = '0; i_shift8 = '0; o_ready8 = 1'b1;
        i_valid6 = 4'b0000; i_bits6 = '0; i_shift6 = '0; o_ready6 = 1'b1;

        // Reset state. The requests are active, but no grant may be issued.
        @(posedge clk); #1;
        check("rst_o_valid", 64'(o_valid8), 64'd0);
        check("rst_o_bits",  64'(o_bits8),  64'd0);
        check("rst_o_src",   64'(o_src8),   64'd0);
        check("rst_i_ready", 64'(i_ready8), 64'd0);

        // Single request from requester 0.
        @(negedge clk);
        rst_n = 1'b1;
        i_valid8 = 4'b0001;
        set_req8(0, 8'h81, 3'd1);
        #1 check("single_i_ready", 64'(i_ready8), 64'b0001);
        @(posedge clk); #1;
        check("single_o_valid", 64'(o_valid8), 64'd1);
        check("single_o_bits",  64'(o_bits8),  64'(exp8[0]));
        check("single_o_src",   64'(o_src8),   64'd0);

        // Asynchronous reset clears a valid result before the next edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("async_rst_o_valid", 64'(o_valid8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // All requesters active: grants go 0,1,2,3,0.
        set_req8(1, 8'h0F, 3'd4);
        set_req8(2, 8'hA5, 3'd3);
        set_req8(3, 8'h01, 3'd7);
        i_valid8 = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            #1 check($sformatf("rr%0d_i_ready", n), 64'(i_ready8), 64'(4'b0001 << (n % 4)));
            @(posedge clk); #1;
            check($sformatf("rr%0d_o_src", n),  64'(o_src8),  64'(n % 4));
            check($sformatf("rr%0d_o_bits", n), 64'(o_bits8), 64'(exp8[n % 4]));
            @(negedge clk);
        end

        // Backpressure: the result holds and nothing is accepted. ptr is now 1.
        o_ready8 = 1'b0;
        i_valid8 = 4'b0010;
        for (int n = 0; n < 3; n++) begin
            #1 check($sformatf("stall%0d_i_ready", n), 64'(i_ready8), 64'd0);
            @(posedge clk); #1;
            check($sformatf("stall%0d_o_valid", n), 64'(o_valid8), 64'd1);
            check($sformatf("stall%0d_o_bits", n),  64'(o_bits8),  64'(exp8[0]));
            @(negedge clk);
        end
        o_ready8 = 1'b1;
        #1 check("unstall_i_ready", 64'(i_ready8), 64'b0010);
        @(posedge clk); #1;
        check("unstall_o_src",  64'(o_src8),  64'd1);
        check("unstall_o_bits", 64'(o_bits8), 64'(exp8[1]));

        // Drain with no request: o_valid drops and the data registers hold.
        @(negedge clk);
        i_valid8 = 4'b0000;
        #1 check("drain_i_ready", 64'(i_ready8), 64'd0);
        @(posedge clk); #1;
        check("drain_o_valid", 64'(o_valid8), 64'd0);
        check("drain_o_bits",  64'(o_bits8),  64'(exp8[1]));
        check("drain_o_src",   64'(o_src8),   64'd1);

        // ptr=2 with requests 0 and 3: requester 3 wins, then ptr wraps to 0.
        @(negedge clk);
        i_valid8 = 4'b1001;
        #1 check("wrap_i_ready3", 64'(i_ready8), 64'b1000);
        @(posedge clk); #1;
        check("wrap_o_src3", 64'(o_src8), 64'd3);
        check("wrap_o_bits3", 64'(o_bits8), 64'(exp8[3]));
        @(negedge clk);
        #1 check("wrap_i_ready0", 64'(i_ready8), 64'b0001);
        @(posedge clk); #1;
        check("wrap_o_src0", 64'(o_src8), 64'd0);

        // Mid-cycle reset pulse while o_valid=1, then a grant starting from ptr=0.
        @(negedge clk);
        i_valid8 = 4'b1010;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_o_valid", 64'(o_valid8), 64'd0);
        check("midrst_o_bits",  64'(o_bits8),  64'd0);
        check("midrst_i_ready", 64'(i_ready8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("postrst_i_ready", 64'(i_ready8), 64'b0010);
        @(posedge clk); #1;
        check("postrst_o_src",   64'(o_src8),   64'd1);
        check("postrst_o_valid", 64'(o_valid8), 64'd1);

        // width=6: a shift of 7 is out of range.
        @(negedge clk);
        i_valid8 = 4'b0000;
        i_valid6 = 4'b0001;
        set_req6(0, 6'h3F, 3'd7);
        #1 check("w6_i_ready", 64'(i_ready6), 64'b0001);
        @(posedge clk); #1;
        check("w6_big_shift_o_bits", 64'(o_bits6), ROT ? 64'h3F : 64'h00);
        @(negedge clk);
        i_valid6 = 4'b0010;
        set_req6(1, 6'h21, 3'd1);
        @(posedge clk); #1;
        check("w6_shift1_o_bits", 64'(o_bits6), ROT ? 64'h03 : 64'h02);
        check("w6_shift1_o_src",  64'(o_src6),  64'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
